// File: rtl/dino_motion_ctrl_if.sv
// Player-side signal bundle for dino_motion_ctrl.
// The game logic drives button/halt/restart; the motion block returns its outputs.
interface dino_motion_ctrl_if;
  logic       button;
  logic       halt;
  logic       restart;
  logic [6:0] jumpaddr;
  logic       sprite;
  logic [4:0] random1;

  modport master (
    output button, halt, restart,
    input  jumpaddr, sprite, random1
  );

  modport slave (
    input  button, halt, restart,
    output jumpaddr, sprite, random1
  );
endinterface

// File: rtl/dino_motion_ctrl.sv
// Per-player motion block: jump trajectory, running-sprite toggle and an
// LFSR-derived random value latched on each button press.
module dino_motion_ctrl #(
  parameter int          TICK_DIV  = 1_000_000,
  parameter int          ANIM_DIV  = 10_000_000,
  parameter int          JUMP_V0   = 9,
  parameter int          GRAVITY   = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic               clk,
  input logic               reset_n,
  dino_motion_ctrl_if.slave bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ANIM_W-1:0] C_ANIM_LAST = ANIM_W'(ANIM_DIV - 1);
  localparam logic [6:0]        C_H0        = 7'(JUMP_V0);
  localparam logic signed [7:0] C_V0        = 8'(JUMP_V0);
  localparam logic signed [7:0] C_G         = 8'(GRAVITY);

  typedef enum logic {S_IDLE, S_AIR} state_t;

  // Height saturates at the top of the 7-bit range; n <= 0 is handled as landing.
  function automatic logic [6:0] sat_height(input logic signed [8:0] n);
    if (n > 9'sd127) return 7'd127;
    return n[6:0];
  endfunction

  logic                r_btn_meta, r_btn_s, r_btn_prev;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [ANIM_W-1:0]   r_anim_cnt;
  state_t              r_state;
  logic [6:0]          r_h;
  logic signed [7:0]   r_v;
  logic                r_sprite;
  logic [15:0]         r_lfsr;
  logic [4:0]          r_random1;

  logic                w_tick, w_anim, w_btn_rise, w_fb;
  logic signed [8:0]   w_sum;

  assign w_tick     = (r_tick_cnt == C_TICK_LAST);
  assign w_anim     = (r_anim_cnt == C_ANIM_LAST);
  assign w_btn_rise = r_btn_s & ~r_btn_prev;
  assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_sum      = $signed({2'b00, r_h}) + $signed({r_v[7], r_v});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_meta <= bus.button;
      r_btn_s    <= r_btn_meta;
      r_btn_prev <= r_btn_s;
    end
  end

  // Free-running timebases; game control never disturbs them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
      r_anim_cnt <= '0;
      r_sprite   <= 1'b1;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
      r_anim_cnt <= w_anim ? '0 : r_anim_cnt + ANIM_W'(1);
      if (w_anim) r_sprite <= ~r_sprite;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= '0;
    end else if (bus.restart) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= '0;
    end else if (!bus.halt && w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_btn_s) begin
            r_h     <= C_H0;
            r_v     <= C_V0 - C_G;
            r_state <= S_AIR;
          end else begin
            r_h <= '0;
          end
        end
        S_AIR: begin
          // Button is deliberately ignored here: no mid-air relaunch.
          if (w_sum <= 9'sd0) begin
            r_h     <= '0;
            r_v     <= '0;
            r_state <= S_IDLE;
          end else begin
            r_h <= sat_height(w_sum);
            r_v <= r_v - C_G;
          end
        end
      endcase
    end
  end

  // Nonzero seed keeps the LFSR out of its lock-up state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr    <= LFSR_SEED;
      r_random1 <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      if (w_btn_rise) r_random1 <= r_lfsr[4:0];
    end
  end

  assign bus.jumpaddr = r_h;
  assign bus.sprite   = r_sprite;
  assign bus.random1  = r_random1;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Bench for dino_motion_ctrl with short tick/anim periods; expectations come
// from closed-form trajectory, edge-count timing and an LFSR reference.
module tb_dino_motion_ctrl;
  localparam int          TD   = 4;
  localparam int          AD   = 8;
  localparam int          V0   = 9;
  localparam int          G    = 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   edge_cnt;
  int   n_tests = 0;
  int   n_fail  = 0;

  dino_motion_ctrl_if bus();

  dino_motion_ctrl #(
    .TICK_DIV(TD), .ANIM_DIV(AD), .JUMP_V0(V0), .GRAVITY(G), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset release; edge k is a tick when k % TD == 0.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;

  // Height after j physics ticks counted from launch (j=1 is the launch tick).
  function automatic int traj(int j);
    int h;
    if (j <= 0) return 0;
    h = j * V0 - (G * j * (j - 1)) / 2;
    if (h <= 0) return 0;
    return (h > 127) ? 127 : h;
  endfunction

  function automatic int first_tick(int e);
    return ((e + TD - 1) / TD) * TD;
  endfunction

  function automatic logic exp_sprite(int e);
    return ((e / AD) % 2) == 0;
  endfunction

  function automatic logic [15:0] lfsr_after(int n);
    logic [15:0] l;
    l = SEED;
    for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction

  function automatic int jump_exp(int x, int l);
    return (x >= l) ? traj((x - l) / TD + 1) : 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.button = 1'b0; bus.halt = 1'b0; bus.restart = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int e0;
    @(negedge clk);
    reset_n = 1'b0;
    bus.button = 1'b0; bus.halt = 1'b0; bus.restart = 1'b0;
    #1;
    n_tests++; if (bus.jumpaddr !== 7'd0) begin n_fail++; $display("FAIL reset_jumpaddr: got %0d expected 0", bus.jumpaddr); end
    n_tests++; if (bus.sprite !== 1'b1) begin n_fail++; $display("FAIL reset_sprite: got %0b expected 1", bus.sprite); end
    n_tests++; if (bus.random1 !== 5'd0) begin n_fail++; $display("FAIL reset_random1: got %0d expected 0", bus.random1); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.sprite !== exp_sprite(edge_cnt) || bus.jumpaddr !== 7'd0) begin
        n_fail++;
        $display("FAIL sprite_run: edge %0d got sprite=%0b h=%0d expected sprite=%0b h=0", edge_cnt, bus.sprite, bus.jumpaddr, exp_sprite(edge_cnt));
      end
    end
    e0 = edge_cnt;
    bus.button = 1'b1;
    repeat (12) @(negedge clk);
    n_tests++;
    if (bus.random1 !== lfsr_after(e0 + 2)[4:0]) begin
      n_fail++; $display("FAIL pre_reset_random1: got %0d expected %0d", bus.random1, lfsr_after(e0 + 2)[4:0]);
    end
    n_tests++;
    if (bus.jumpaddr !== 7'(jump_exp(edge_cnt, first_tick(e0 + 3)))) begin
      n_fail++; $display("FAIL pre_reset_jump: got %0d expected %0d", bus.jumpaddr, jump_exp(edge_cnt, first_tick(e0 + 3)));
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (bus.jumpaddr !== 7'd0) begin n_fail++; $display("FAIL async_reset_jumpaddr: got %0d expected 0", bus.jumpaddr); end
    n_tests++; if (bus.sprite !== 1'b1) begin n_fail++; $display("FAIL async_reset_sprite: got %0b expected 1", bus.sprite); end
    n_tests++; if (bus.random1 !== 5'd0) begin n_fail++; $display("FAIL async_reset_random1: got %0d expected 0", bus.random1); end
    bus.button = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_full_jump();
    int e0, l;
    do_reset();
    repeat ($urandom_range(0, 7)) @(negedge clk);
    e0 = edge_cnt; l = first_tick(e0 + 3);
    bus.button = 1'b1;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (edge_cnt == e0 + 10) bus.button = 1'b0;
      n_tests++;
      if (bus.jumpaddr !== 7'(jump_exp(edge_cnt, l))) begin
        n_fail++; $display("FAIL full_jump: edge %0d got %0d expected %0d", edge_cnt, bus.jumpaddr, jump_exp(edge_cnt, l));
      end
    end
  endtask

  task automatic test_no_double_jump();
    int e0, l;
    do_reset();
    repeat ($urandom_range(0, 7)) @(negedge clk);
    e0 = edge_cnt; l = first_tick(e0 + 3);
    bus.button = 1'b1;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (edge_cnt == e0 + 10)     bus.button = 1'b0;
      if (edge_cnt == l + 8 * TD)  bus.button = 1'b1;
      if (edge_cnt == l + 8 * TD + 6) bus.button = 1'b0;
      n_tests++;
      if (bus.jumpaddr !== 7'(jump_exp(edge_cnt, l))) begin
        n_fail++; $display("FAIL no_double_jump: edge %0d got %0d expected %0d", edge_cnt, bus.jumpaddr, jump_exp(edge_cnt, l));
      end
    end
  endtask

  task automatic test_halt_restart();
    int e0, l, r, l1;
    do_reset();
    repeat ($urandom_range(0, 7)) @(negedge clk);
    e0 = edge_cnt; l = first_tick(e0 + 3);
    bus.button = 1'b1;
    while (edge_cnt < l + 5 * TD) begin
      @(negedge clk);
      if (edge_cnt == e0 + 10) bus.button = 1'b0;
    end
    n_tests++;
    if (bus.jumpaddr !== 7'd39) begin n_fail++; $display("FAIL pre_halt_height: got %0d expected 39", bus.jumpaddr); end
    bus.halt = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 16) bus.button = 1'b1;
      n_tests++;
      if (bus.jumpaddr !== 7'd39 || bus.sprite !== exp_sprite(edge_cnt)) begin
        n_fail++; $display("FAIL halt_hold: got h=%0d sprite=%0b expected h=39 sprite=%0b", bus.jumpaddr, bus.sprite, exp_sprite(edge_cnt));
      end
    end
    bus.restart = 1'b1;
    @(negedge clk);
    r = edge_cnt;
    bus.restart = 1'b0; bus.halt = 1'b0;
    n_tests++;
    if (bus.jumpaddr !== 7'd0) begin n_fail++; $display("FAIL restart_over_halt: got %0d expected 0", bus.jumpaddr); end
    // Button is already synchronised, so an IDLE block launches on the next tick.
    l1 = first_tick(r + 1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (edge_cnt == r + 4) bus.button = 1'b0;
      n_tests++;
      if (bus.jumpaddr !== 7'(jump_exp(edge_cnt, l1)) || bus.sprite !== exp_sprite(edge_cnt)) begin
        n_fail++; $display("FAIL relaunch_after_restart: edge %0d got h=%0d expected h=%0d", edge_cnt, bus.jumpaddr, jump_exp(edge_cnt, l1));
      end
    end
  endtask

  task automatic test_random_halt();
    int e0, l, j, x;
    logic hv;
    do_reset();
    repeat ($urandom_range(0, 7)) @(negedge clk);
    e0 = edge_cnt; l = first_tick(e0 + 3);
    bus.button = 1'b1;
    j = 0; hv = 1'b0;
    for (int c = 0; c < 220; c++) begin
      @(negedge clk);
      x = edge_cnt;
      if (x == e0 + 10) bus.button = 1'b0;
      if (x == l) j = 1;
      else if (x > l && (x % TD) == 0 && !hv) j++;
      n_tests++;
      if (bus.jumpaddr !== 7'(traj(j)) || bus.sprite !== exp_sprite(x)) begin
        n_fail++; $display("FAIL random_halt: edge %0d got h=%0d sprite=%0b expected h=%0d sprite=%0b", x, bus.jumpaddr, bus.sprite, traj(j), exp_sprite(x));
      end
      hv = (x >= l) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.halt = hv;
    end
    bus.halt = 1'b0;
  endtask

  task automatic test_rng();
    int e0;
    logic [4:0] exp_r;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      repeat ($urandom_range(3, 60)) @(negedge clk);
      e0 = edge_cnt;
      exp_r = lfsr_after(e0 + 2)[4:0];
      bus.button = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (bus.random1 !== 5'd0) begin n_fail++; $display("FAIL rng_early: got %0d expected 0", bus.random1); end
      @(negedge clk);
      n_tests++;
      if (bus.random1 !== exp_r) begin n_fail++; $display("FAIL rng_load: got %0d expected %0d", bus.random1, exp_r); end
      repeat (6) @(negedge clk);
      n_tests++;
      if (bus.random1 !== exp_r) begin n_fail++; $display("FAIL rng_hold: got %0d expected %0d", bus.random1, exp_r); end
      bus.button = 1'b0;
    end
  endtask

  task automatic test_lfsr();
    int period;
    logic zero_seen;
    do_reset();
    period = 0; zero_seen = 1'b0;
    for (int c = 1; c <= 70000; c++) begin
      @(negedge clk);
      if (dut.r_lfsr == 16'h0) zero_seen = 1'b1;
      if (period == 0 && dut.r_lfsr == SEED) period = c;
    end
    n_tests++;
    if (zero_seen !== 1'b0) begin n_fail++; $display("FAIL lfsr_zero: got zero state expected never zero"); end
    n_tests++;
    if (period != 65535) begin n_fail++; $display("FAIL lfsr_period: got %0d expected 65535", period); end
    n_tests++;
    if (dut.r_lfsr !== lfsr_after(edge_cnt)) begin
      n_fail++; $display("FAIL lfsr_value: got %h expected %h", dut.r_lfsr, lfsr_after(edge_cnt));
    end
  endtask

  initial begin
    bus.button = 1'b0; bus.halt = 1'b0; bus.restart = 1'b0;
    test_reset();
    test_full_jump();
    test_no_double_jump();
    test_halt_restart();
    test_random_halt();
    test_rng();
    test_lfsr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dino_motion_ctrl.md
# dino_motion_ctrl

Per-player motion and entropy block for the dino runner game. It combines three functions: the vertical jump trajectory (`jumpaddr`), the two-frame running-animation select (`sprite`), and a 5-bit pseudo-random value (`random1`) used to pick cactus types. It sits beside the VGA timing and scroll blocks, and its outputs feed the top-level pixel compositor directly. Collision logic drives `halt` and `restart`.

## Interface
Parameters:
- `TICK_DIV`, default 1_000_000: clk cycles per physics tick (100 Hz at 100 MHz).
- `ANIM_DIV`, default 10_000_000: clk cycles per sprite toggle.
- `JUMP_V0`, default 9: launch velocity in pixels/tick.
- `GRAVITY`, default 1: velocity decrement per tick.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`, in, 1: single system clock. All logic is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `button`, in, 1: raw player button, asynchronous to `clk`.
- `halt`, in, 1: game-over freeze (collision).
- `restart`, in, 1: synchronous active-high game restart pulse.
- `jumpaddr`, out, 7: dino height above ground in pixels. 0 means on ground.
- `sprite`, out, 1: running frame select (1 = frame A, 0 = frame B).
- `random1`, out, 5: latched random value.

## Operation
- **Button synchronizer:** `button` passes through a 2-flop synchronizer. All internal uses see `btn_s`, which lags `button` by 2 cycles. Reset value is 0.
- **Tick generators:** two free-running counters, `tick_cnt` (0..TICK_DIV-1) and `anim_cnt` (0..ANIM_DIV-1). Each wraps to 0 and is never affected by `halt` or `restart`.
  - `tick` is asserted combinationally when `tick_cnt == TICK_DIV-1`.
  - `anim` is asserted combinationally when `anim_cnt == ANIM_DIV-1`.
- **Jump FSM:**
  - State: IDLE/AIR, height `h` (unsigned 7-bit, drives `jumpaddr`), velocity `v` (signed 8-bit).
  - Priority per edge: `restart` first, then `halt`, then `tick`.
  - `restart`: h=0, v=0, IDLE, on any edge regardless of `tick`.
  - `halt` (without `restart`): h, v and state hold.
  - IDLE on `tick` with `btn_s`=1: h=JUMP_V0, v=JUMP_V0-GRAVITY, go to AIR. With `btn_s`=0: stay IDLE, h=0.
  - AIR on `tick`: compute n = h + v as a signed 9-bit value.
    - If n ≤ 0: h=0, v=0, go to IDLE.
    - Else if n > 127: h=127 (clamp) and v = v - GRAVITY.
    - Otherwise h = n and v = v - GRAVITY.
  - `btn_s` is ignored while in AIR; no double jump. Holding the button keeps re-launching on the first tick after landing.
  - With the defaults the trajectory is 9,17,24,30,35,39,42,44,45,45,44,42,39,35,30,24,17,9,0. Apex is 45, reached on tick 9. Landing (IDLE) occurs on tick 19 counted from launch.
- **Sprite:** `sprite` toggles on every `anim` edge. It is free-running and ignores `halt` and `restart`.
- **RNG:**
  - 16-bit Fibonacci LFSR with taps 16,14,13,11: feedback = l[15]^l[13]^l[12]^l[10], shifted into l[0]. It advances every clk and cannot reach the all-zero state.
  - `random1` loads `lfsr[4:0]` on the rising edge of `btn_s` (btn_s=1 while the previous btn_s=0); otherwise it holds.

## Timing
- Reset values:
  - h=0, v=0, IDLE, so `jumpaddr`=0.
  - `sprite`=1 and `random1`=0.
  - lfsr=LFSR_SEED, both counters=0, synchronizer flops=0.
- All outputs are registered, with no combinational path from inputs to outputs.
- `jumpaddr` changes only on tick edges or on `restart`.
- Button to launch: the first tick edge at least 2 cycles after `button` rises, i.e. once `btn_s`=1.
- First `sprite` toggle is at edge ANIM_DIV after reset release; first `tick` is at edge TICK_DIV.
- `random1` update happens 3 edges after `button` rises: 2 synchronizer edges plus 1 load edge. It uses the LFSR value present before that edge's shift.
- `halt` and `restart` asserted on the same edge: `restart` wins.
- `reset_n` asserted mid-jump: immediate asynchronous return to reset values.

## Test plan
- **Reset values:** TICK_DIV=4, ANIM_DIV=8. Assert `reset_n`=0 mid-simulation → `jumpaddr`=0, `sprite`=1 and `random1`=0 immediately. After release, `sprite` toggles every 8 cycles.
- **Full jump:** TICK_DIV=4, hold `button` for 10 cycles → `jumpaddr` follows 9,17,…,45,45,…,9,0, one value per tick. It is 0 (IDLE) on tick 19.
- **No double jump:** pulse `button` again at apex (h=45) → trajectory is unchanged.
- **Halt and restart:** assert `halt` at h=39 for 20 cycles → `jumpaddr` stays 39. Then pulse `restart` with `halt` still high → `jumpaddr`=0 on the next edge and the block is IDLE.
- **RNG:** after reset, wait k cycles, then raise `button` → `random1` equals bits [4:0] of the LFSR value obtained from 0xACE1 after the correct number of shifts. It stays stable while `button` is held.
- **LFSR sanity:** run the LFSR for 70000 cycles → lfsr is never zero and its period is 65535.
